// File: rtl/dmc_dma_responder.sv
// DPCM sample-fetch responder: halts the core through RDY, waits for a read cycle, aligns to a get cycle, reads one byte.
// Latency 3-4 cycles from acceptance plus one per core write seen while halting; DMC_REQ is a held level released only by DMC_ACK.
`timescale 1ns/1ps
module dmc_dma_responder (
  input  logic        PHI0,
  input  logic        n_RES,
  input  logic        ACLK,
  input  logic        RnW,
  input  logic        LOCK,
  input  logic        DMC_REQ,
  input  logic [15:0] DMC_Addr,
  input  logic [7:0]  DB_IN,
  output logic        RDY,
  output logic        n_DMCAB,
  output logic [15:0] ADDR,
  output logic [7:0]  RD_DATA,
  output logic        DMC_ACK
);

  typedef enum logic [2:0] {IDLE, HALT, DUMMY, ALIGN, FETCH} state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // Blocking on DMC_ACK keeps a request still high in the ACK cycle from retriggering.
        if (DMC_REQ && !LOCK && !DMC_ACK) begin
          accept    = 1'b1;
          state_nxt = HALT;
        end
      end
      HALT:    if (RnW) state_nxt = DUMMY;
      DUMMY:   state_nxt = ACLK ? ALIGN : FETCH;
      ALIGN:   state_nxt = FETCH;
      FETCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs come from their own flops, loaded from the next state so they line up with it.
  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      state   <= IDLE;
      RDY     <= 1'b1;
      n_DMCAB <= 1'b1;
      DMC_ACK <= 1'b0;
      RD_DATA <= 8'h00;
      ADDR    <= 16'h0000;
    end else begin
      state   <= state_nxt;
      RDY     <= (state_nxt == IDLE);
      n_DMCAB <= (state_nxt != FETCH);
      DMC_ACK <= (state == FETCH);
      if (accept) ADDR <= DMC_Addr;
      if (state == FETCH) RD_DATA <= DB_IN;
    end
  end

endmodule

// File: tb/tb_dmc_dma_responder.sv
// Bench for dmc_dma_responder: timeline reference model checked every cycle, plus directed transactions with literal expectations.
`timescale 1ns/1ps
module tb_dmc_dma_responder;

  logic        PHI0 = 1'b0;
  logic        n_RES;
  logic        ACLK;
  logic        RnW;
  logic        LOCK;
  logic        DMC_REQ;
  logic [15:0] DMC_Addr;
  logic [7:0]  DB_IN;
  logic        RDY;
  logic        n_DMCAB;
  logic [15:0] ADDR;
  logic [7:0]  RD_DATA;
  logic        DMC_ACK;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  dmc_dma_responder dut (
    .PHI0(PHI0), .n_RES(n_RES), .ACLK(ACLK), .RnW(RnW), .LOCK(LOCK),
    .DMC_REQ(DMC_REQ), .DMC_Addr(DMC_Addr), .DB_IN(DB_IN),
    .RDY(RDY), .n_DMCAB(n_DMCAB), .ADDR(ADDR), .RD_DATA(RD_DATA), .DMC_ACK(DMC_ACK)
  );

  always #5 PHI0 = ~PHI0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the cycle numbers at which each phase of a request happens.
  // Cycle e is the cycle that begins at clock edge number e.
  int          cyc      = 0;
  int          m_e;
  bit          m_busy   = 1'b0;
  bit          m_halted = 1'b0;
  int          m_dummy  = -100;
  int          m_fetch  = -100;
  int          m_ack    = -100;
  logic [15:0] m_addr   = 16'h0000;
  logic [7:0]  m_rd     = 8'h00;

  always @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      m_busy = 1'b0; m_halted = 1'b0;
      m_dummy = -100; m_fetch = -100; m_ack = -100;
      m_addr = 16'h0000; m_rd = 8'h00;
    end else begin
      cyc++;
      m_e = cyc;
      if (m_busy && m_fetch == m_e - 1) begin
        m_rd = DB_IN; m_ack = m_e; m_busy = 1'b0;
      end else if (m_busy && m_halted && m_fetch < 0 && m_e == m_dummy + 1) begin
        // The fetch must land on a get cycle; ACLK alternates, so one more cycle fixes a mismatch.
        m_fetch = ACLK ? m_e + 1 : m_e;
      end else if (m_busy && !m_halted && RnW) begin
        m_halted = 1'b1; m_dummy = m_e;
      end else if (!m_busy && DMC_REQ && !LOCK && m_ack != m_e - 1) begin
        m_busy = 1'b1; m_halted = 1'b0; m_fetch = -100; m_addr = DMC_Addr;
      end
    end
  end

  always @(negedge PHI0) begin
    if (chk_en && n_RES) begin
      chk("rdy",     32'(RDY),     32'(!m_busy));
      chk("n_dmcab", 32'(n_DMCAB), 32'(!(m_busy && m_fetch == cyc)));
      chk("ack",     32'(DMC_ACK), 32'(m_ack == cyc));
      chk("rd_data", 32'(RD_DATA), 32'(m_rd));
      chk("addr",    32'(ADDR),    32'(m_addr));
      if (!n_DMCAB) chk("fetch_on_get", 32'(ACLK), 32'd1);
    end
  end

  // Measurement counters for the directed transactions.
  bit          mon_en = 1'b0;
  int          rdy_low, dmcab_low, acks, accepts;
  logic [15:0] fetch_addr;
  logic        fetch_aclk;
  logic        prev_rdy;

  always @(negedge PHI0) begin
    if (mon_en) begin
      if (!RDY) rdy_low++;
      if (prev_rdy && !RDY) accepts++;
      prev_rdy = RDY;
      if (!n_DMCAB) begin
        dmcab_low++; fetch_addr = ADDR; fetch_aclk = ACLK;
      end
      if (DMC_ACK) acks++;
    end
  end

  task automatic mon_start();
    rdy_low = 0; dmcab_low = 0; acks = 0; accepts = 0;
    fetch_addr = 16'h0000; fetch_aclk = 1'b0; prev_rdy = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic tick();
    @(posedge PHI0);
    #1;
    ACLK = ~ACLK;
  endtask

  task automatic wait_ack(input string name);
    for (int k = 0; k < 16 && !DMC_ACK; k++) tick();
    chk(name, 32'(DMC_ACK), 32'd1);
  endtask

  // One request with w write cycles during HALT; aligned chooses ACLK=0 in the DUMMY cycle.
  task automatic transaction(input logic [15:0] a, input logic [7:0] d, input int w,
                             input bit aligned, input int exp_low);
    logic want;
    want = aligned ? w[0] : ~w[0];
    while (ACLK != want) tick();
    DMC_REQ = 1'b1; DMC_Addr = a; DB_IN = d; RnW = 1'b1; LOCK = 1'b0;
    mon_start();
    tick();
    DMC_Addr = ~a;
    LOCK = 1'b1;
    for (int i = 0; i < w; i++) begin
      RnW = 1'b0;
      tick();
    end
    RnW = 1'b1;
    wait_ack("txn_ack_timeout");
    DMC_REQ = 1'b0;
    LOCK = 1'b0;
    tick();
    mon_en = 1'b0;
    chk("txn_rdy_low_cycles", 32'(rdy_low), 32'(exp_low));
    chk("txn_dmcab_cycles", 32'(dmcab_low), 32'd1);
    chk("txn_fetch_addr", 32'(fetch_addr), 32'(a));
    chk("txn_fetch_aclk", 32'(fetch_aclk), 32'd1);
    chk("txn_rd_data", 32'(RD_DATA), 32'(d));
    chk("txn_ack_pulses", 32'(acks), 32'd1);
  endtask

  initial begin
    n_RES = 1'b0; ACLK = 1'b0; RnW = 1'b1; LOCK = 1'b0;
    DMC_REQ = 1'b0; DMC_Addr = 16'h0000; DB_IN = 8'h00;
    repeat (3) tick();
    chk("reset_rdy", 32'(RDY), 32'd1);
    chk("reset_n_dmcab", 32'(n_DMCAB), 32'd1);
    chk("reset_ack", 32'(DMC_ACK), 32'd0);
    chk("reset_rd_data", 32'(RD_DATA), 32'h00);
    chk("reset_addr", 32'(ADDR), 32'h0000);
    n_RES = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    transaction(16'hC123, 8'h5A, 0, 1'b1, 3);
    transaction(16'h8001, 8'hA5, 0, 1'b0, 4);
    transaction(16'hF00D, 8'h3C, 3, 1'b1, 6);
    transaction(16'h4242, 8'hE7, 3, 1'b0, 7);

    // LOCK blocks acceptance; a request held through the ACK cycle re-arms exactly once.
    DMC_REQ = 1'b1; LOCK = 1'b1; DMC_Addr = 16'h1234; DB_IN = 8'h77; RnW = 1'b1;
    mon_start();
    repeat (5) tick();
    chk("lock_rdy_low_cycles", 32'(rdy_low), 32'd0);
    chk("lock_rdy", 32'(RDY), 32'd1);
    LOCK = 1'b0;
    tick();
    chk("unlock_accept", 32'(RDY), 32'd0);
    wait_ack("lock_ack_timeout");
    tick();
    chk("no_retrigger_in_ack", 32'(RDY), 32'd1);
    tick();
    chk("reaccept_after_ack", 32'(RDY), 32'd0);
    DMC_REQ = 1'b0;
    wait_ack("reaccept_ack_timeout");
    tick();
    mon_en = 1'b0;
    chk("lock_accepts", 32'(accepts), 32'd2);
    chk("lock_acks", 32'(acks), 32'd2);
    chk("lock_rd_data", 32'(RD_DATA), 32'h77);

    // Reset while in DUMMY abandons the fetch.
    DMC_REQ = 1'b1; DMC_Addr = 16'hBEEF; DB_IN = 8'h99; RnW = 1'b1;
    tick();
    tick();
    #1;
    n_RES = 1'b0;
    #1;
    chk("midreset_rdy", 32'(RDY), 32'd1);
    chk("midreset_n_dmcab", 32'(n_DMCAB), 32'd1);
    chk("midreset_ack", 32'(DMC_ACK), 32'd0);
    chk("midreset_rd_data", 32'(RD_DATA), 32'h00);
    chk("midreset_addr", 32'(ADDR), 32'h0000);
    DMC_REQ = 1'b0;
    tick();
    tick();
    n_RES = 1'b1;
    mon_start();
    repeat (8) tick();
    mon_en = 1'b0;
    chk("postreset_acks", 32'(acks), 32'd0);
    chk("postreset_rdy_low", 32'(rdy_low), 32'd0);
    transaction(16'h0F0F, 8'hC3, 1, 1'b0, 5);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      tick();
      RnW  = ($urandom_range(0, 9) < 7);
      LOCK = ($urandom_range(0, 19) == 0);
      DB_IN = 8'($urandom);
      if ($urandom_range(0, 3) == 0) DMC_Addr = 16'($urandom);
      if (DMC_ACK) DMC_REQ = ($urandom_range(0, 3) == 0);
      else if (!DMC_REQ) DMC_REQ = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 49) == 0) DMC_REQ = 1'b0;
      if ($urandom_range(0, 999) == 0) begin
        n_RES = 1'b0;
        #2;
        n_RES = 1'b1;
      end
    end
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
